// File: rtl/counter_driver_pkg.sv
// Shared types and default sizes for the counter driver and its reference model.
package counter_drv_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int STEP_W_DEF = 16;
    localparam int ERR_W_DEF  = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_UP    = 2'd1,
        OP_DOWN  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/counter_driver_ref_model.sv
// Expected-count tracker for an up/down counter: clear, load, then +/-1 with
// modulo-2^WIDTH wrap, using the same priority as the counter itself.
module counter_ref_model
    import counter_drv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             step,
    input  logic             up,
    output logic [WIDTH-1:0] exp_count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            exp_count <= '0;
        end else if (load) begin
            exp_count <= load_data;
        end else if (step) begin
            exp_count <= up ? exp_count + 1'b1 : exp_count - 1'b1;
        end
    end

endmodule

// File: rtl/counter_driver.sv
// Command-driven initiator for an up/down counter: sequences load/clear/count
// controls, tracks the expected count and reports the observed count plus mismatch.
module counter_driver
    import counter_drv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_count,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              cnt_rst_n,
    output logic              cnt_load_n,
    output logic              cnt_up_down,
    output logic              cnt_ce,
    output logic [WIDTH-1:0]  cnt_data_load,
    input  logic [WIDTH-1:0]  cnt_count_out,
    output state_e            state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // the source holds valid and payload stable until then, and ready never depends on valid.
    state_e              state;
    cmd_op_e             op_q;
    logic [WIDTH-1:0]    data_q;
    logic [STEP_W-1:0]   steps_left;
    logic [WIDTH-1:0]    exp_count;
    logic                ref_clear;
    logic                ref_load;
    logic                ref_step;
    logic                ref_up;
    logic                mismatch;

    assign state_dbg = state;
    assign ref_clear = (state == DRIVE) && (op_q == OP_CLEAR);
    assign ref_load  = (state == DRIVE) && (op_q == OP_LOAD);
    assign ref_step  = (state == RUN);
    assign ref_up    = (op_q == OP_UP);
    assign mismatch  = (cnt_count_out != exp_count);

    counter_ref_model #(.WIDTH(WIDTH)) u_ref (
        .clk       (clk),
        .rst       (rst),
        .clear     (ref_clear),
        .load      (ref_load),
        .load_data (data_q),
        .step      (ref_step),
        .up        (ref_up),
        .exp_count (exp_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            op_q          <= OP_LOAD;
            data_q        <= '0;
            steps_left    <= '0;
            rsp_valid     <= 1'b0;
            rsp_count     <= '0;
            rsp_err       <= 1'b0;
            err_count     <= '0;
            cnt_rst_n     <= 1'b0;
            cnt_load_n    <= 1'b1;
            cnt_up_down   <= 1'b1;
            cnt_ce        <= 1'b0;
            cnt_data_load <= '0;
        end else begin
            // Controls fall back to idle unless the next state drives them.
            cnt_rst_n  <= 1'b1;
            cnt_load_n <= 1'b1;
            cnt_ce     <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        op_q       <= cmd_op_e'(cmd_op);
                        data_q     <= cmd_data;
                        steps_left <= cmd_steps;
                        case (cmd_op_e'(cmd_op))
                            OP_LOAD: begin
                                state         <= DRIVE;
                                cnt_load_n    <= 1'b0;
                                cnt_data_load <= cmd_data;
                            end
                            OP_CLEAR: begin
                                state     <= DRIVE;
                                cnt_rst_n <= 1'b0;
                            end
                            default: begin
                                if (cmd_steps != '0) begin
                                    state       <= RUN;
                                    cnt_ce      <= 1'b1;
                                    cnt_up_down <= (cmd_op_e'(cmd_op) == OP_UP);
                                end else begin
                                    state <= SETTLE;
                                end
                            end
                        endcase
                    end
                end
                DRIVE: begin
                    state <= SETTLE;
                end
                RUN: begin
                    steps_left <= steps_left - 1'b1;
                    if (steps_left == STEP_W'(1)) begin
                        state <= SETTLE;
                    end else begin
                        cnt_ce <= 1'b1;
                    end
                end
                SETTLE: begin
                    rsp_valid <= 1'b1;
                    rsp_count <= cnt_count_out;
                    rsp_err   <= mismatch;
                    if (mismatch && (err_count != {ERR_W{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_driver.sv
// Randomized scoreboard bench for counter_driver with an attached behavioural
// counter (plus a stuck-output fault switch) and a high-level expected-count model.
module tb_counter_driver;
    import counter_drv_pkg::*;

    localparam int W     = 4;
    localparam int SW    = 16;
    localparam int EW    = 8;
    localparam int EXP_W = 69;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [SW-1:0] cmd_steps;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_count;
    logic          rsp_err;
    logic [EW-1:0] err_count;
    logic          cnt_rst_n;
    logic          cnt_load_n;
    logic          cnt_up_down;
    logic          cnt_ce;
    logic [W-1:0]  cnt_data_load;
    logic [W-1:0]  cnt_count_out;
    state_e        state_dbg;

    counter_driver #(.WIDTH(W), .STEP_W(SW), .ERR_W(EW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_steps     (cmd_steps),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_count     (rsp_count),
        .rsp_err       (rsp_err),
        .err_count     (err_count),
        .cnt_rst_n     (cnt_rst_n),
        .cnt_load_n    (cnt_load_n),
        .cnt_up_down   (cnt_up_down),
        .cnt_ce        (cnt_ce),
        .cnt_data_load (cnt_data_load),
        .cnt_count_out (cnt_count_out),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- attached counter ----------------
    logic [W-1:0] cq;
    logic         stuck;
    always @(posedge clk) begin
        if (!cnt_rst_n)       cq <= '0;
        else if (!cnt_load_n) cq <= cnt_data_load;
        else if (cnt_ce)      cq <= cnt_up_down ? cq + 1'b1 : cq - 1'b1;
    end
    assign cnt_count_out = stuck ? 4'h3 : cq;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int ref_val = 0;
    int err_total = 0;
    bit hold = 1'b0;
    bit rand_bp = 1'b1;
    bit gap_check = 1'b0;

    task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // {latency, up cycles, down cycles, load/clear pulses, err_count, rsp_err, rsp_count}
    function automatic logic [EXP_W-1:0] pack(input int cnt, input bit err, input int ecnt,
                                              input int up_n, input int dn_n, input int pulses,
                                              input int lat);
        return {16'(lat), 16'(up_n), 16'(dn_n), 8'(pulses), 8'(ecnt), err, 4'(cnt)};
    endfunction

    task automatic model_push(input cmd_op_e op, input logic [W-1:0] data, input logic [SW-1:0] steps);
        int n;
        int obs;
        int lat;
        int up_n;
        int dn_n;
        int pulses;
        bit err;
        n = int'(steps);
        up_n = 0;
        dn_n = 0;
        pulses = 0;
        lat = (n == 0) ? 2 : n + 2;
        case (op)
            OP_LOAD:  begin ref_val = int'(data); pulses = 1; lat = 3; end
            OP_CLEAR: begin ref_val = 0;          pulses = 1; lat = 3; end
            OP_UP:    begin ref_val = (ref_val + n) % 16;           up_n = n; end
            default:  begin ref_val = (ref_val + 16 - (n % 16)) % 16; dn_n = n; end
        endcase
        obs = stuck ? 3 : ref_val;
        err = (obs != ref_val);
        if (err && err_total < 255) err_total++;
        exp_q.push_back(pack(obs, err, err_total, up_n, dn_n, pulses, lat));
    endtask

    // ---------------- drivers ----------------
    always @(posedge clk) begin
        #1;
        rsp_ready = hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic issue(input cmd_op_e op, input logic [W-1:0] data, input logic [SW-1:0] steps,
                         input bit expect_rsp);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        @(negedge clk);
        while (!cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%0b expected 1 within 500 cycles", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_rsp) model_push(op, data, steps);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic reset_checks();
        check("rst_cmd_ready",  cmd_ready, 0);
        check("rst_rsp_valid",  rsp_valid, 0);
        check("rst_rsp_count",  rsp_count, 0);
        check("rst_rsp_err",    rsp_err, 0);
        check("rst_err_count",  err_count, 0);
        check("rst_cnt_rst_n",  cnt_rst_n, 0);
        check("rst_cnt_load_n", cnt_load_n, 1);
        check("rst_cnt_ce",     cnt_ce, 0);
        check("rst_up_down",    cnt_up_down, 1);
        check("rst_data_load",  cnt_data_load, 0);
        check("rst_state",      state_dbg, IDLE);
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    int up_seen = 0;
    int dn_seen = 0;
    int pulse_seen = 0;
    bit in_rsp = 1'b0;
    logic [W:0] held;
    logic [EXP_W-1:0] mon_exp;
    logic [EXP_W-1:0] mon_got;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_rsp = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (gap_check) begin
                    check("ready_gap", cyc - hs_cyc, 1);
                    gap_check = 1'b0;
                end
                acc_cyc = cyc;
                up_seen = 0;
                dn_seen = 0;
                pulse_seen = 0;
            end
            if (cnt_ce && cnt_up_down)  up_seen++;
            if (cnt_ce && !cnt_up_down) dn_seen++;
            if (!cnt_load_n || !cnt_rst_n) pulse_seen++;
            if (rsp_valid) begin
                check("busy_cmd_ready", cmd_ready, 0);
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    held = {rsp_err, rsp_count};
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: count=%0h err=%0b with no command pending", rsp_count, rsp_err);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        mon_got = pack(int'(rsp_count), rsp_err, int'(err_count), up_seen, dn_seen,
                                       pulse_seen, cyc - acc_cyc);
                        check("rsp", mon_got, mon_exp);
                    end
                end else begin
                    check("rsp_stable", {rsp_err, rsp_count}, held);
                end
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    hs_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_data = '0;
        cmd_steps = '0;
        rsp_ready = 1'b0;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // directed sequence including wrap and zero-step count
        issue(OP_LOAD, 4'hA, 16'd0, 1'b1);
        issue(OP_UP,   4'h0, 16'd7, 1'b1);
        issue(OP_DOWN, 4'h0, 16'd3, 1'b1);
        issue(OP_UP,   4'h0, 16'd0, 1'b1);
        wait_drain();

        // stuck counter: mismatches, then saturation of err_count
        stuck = 1'b1;
        issue(OP_LOAD, 4'h5, 16'd0, 1'b1);
        repeat (260) issue(OP_LOAD, 4'($urandom_range(4, 15)), 16'd0, 1'b1);
        wait_drain();
        check("err_saturated", err_count, 8'hFF);
        stuck = 1'b0;

        // held response with a competing command waiting
        rand_bp = 1'b0;
        hold = 1'b1;
        issue(OP_LOAD, 4'h9, 16'd0, 1'b1);
        fork
            begin
                int n;
                n = 0;
                while (!rsp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_rsp_seen", rsp_valid, 1);
                repeat (4) @(negedge clk);
                check("bp_still_valid", rsp_valid, 1);
                hold = 1'b0;
            end
            begin
                gap_check = 1'b1;
                issue(OP_UP, 4'h0, 16'd2, 1'b1);
            end
        join
        rand_bp = 1'b1;

        // random commands
        repeat (40) begin
            issue(cmd_op_e'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 20)), 1'b1);
        end
        issue(OP_DOWN, 4'h0, 16'd17, 1'b1);
        wait_drain();

        // reset in the middle of a long count
        issue(OP_UP, 4'h0, 16'd100, 1'b0);
        repeat (20) @(negedge clk);
        check("run_ce_active", cnt_ce, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 rst = 1'b0;
        ref_val = 0;
        err_total = 0;
        issue(OP_CLEAR, 4'h0, 16'd0, 1'b1);
        issue(OP_UP,    4'h0, 16'd5, 1'b1);
        wait_drain();
        check("final_err_count", err_count, err_total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_driver.md
Name: counter_driver

Overview:
Command-driven initiator for the up/down counter's control interface (rst_n, load_n, up_down, ce, data_load, count_out). It accepts high-level commands over a valid/ready handshake: LOAD, COUNT_UP, COUNT_DOWN and CLEAR. It sequences the counter controls cycle by cycle and tracks the expected count internally. On completion it returns the observed count plus a mismatch flag over a valid/ready response channel.

Parameters:
WIDTH, 4, counter data width (data_load / count_out)
STEP_W, 16, width of the step-count field
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0 LOAD, 1 COUNT_UP, 2 COUNT_DOWN, 3 CLEAR
cmd_data  input  WIDTH  load value (LOAD only)
cmd_steps  input  STEP_W  number of enabled count cycles (COUNT_* only)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_count  output  WIDTH  count_out sampled at completion
rsp_err  output  1  1 = rsp_count differs from expected
err_count  output  ERR_W  saturating total of mismatches
cnt_rst_n  output  1  to counter, active-low reset
cnt_load_n  output  1  to counter, active-low load
cnt_up_down  output  1  to counter, 1 = up
cnt_ce  output  1  to counter, count enable
cnt_data_load  output  WIDTH  to counter, load value
cnt_count_out  input  WIDTH  from counter, registered count

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Counter model: synchronous active-low rst_n (highest priority), then load_n, then ce; counts modulo 2^WIDTH.
- Reset values: cmd_ready=0 while rst=1, then 1 the cycle after rst deasserts. rsp_valid=0, rsp_count=0, rsp_err=0, err_count=0. cnt_rst_n=0 while rst=1, else 1. cnt_load_n=1, cnt_ce=0, cnt_up_down=1, cnt_data_load=0. Expected register exp=0. FSM=IDLE.
- FSM states: IDLE, DRIVE, RUN, SETTLE, RESP.
- IDLE: cmd_ready=1. On accept, latch op, data and steps.
  - LOAD -> DRIVE.
  - CLEAR -> DRIVE.
  - COUNT_* with steps>0 -> RUN.
  - COUNT_* with steps=0 -> SETTLE.
- DRIVE (1 cycle):
  - LOAD: cnt_load_n=0, cnt_data_load=data; exp<=data.
  - CLEAR: cnt_rst_n=0; exp<=0.
  - Then -> SETTLE.
- RUN (exactly steps cycles): cnt_ce=1, cnt_up_down=(op==COUNT_UP). exp<=exp±1 mod 2^WIDTH each cycle; remaining steps decrement. Last cycle -> SETTLE.
- SETTLE (1 cycle): all counter controls idle.
  - Compare cnt_count_out against exp.
  - At the clock edge: rsp_count<=cnt_count_out, rsp_err<=(mismatch), rsp_valid<=1.
  - err_count increments on mismatch, saturating at 2^ERR_W-1.
  - -> RESP.
- RESP: rsp_valid, rsp_count and rsp_err held stable until rsp_ready=1. On handshake, rsp_valid<=0 and FSM -> IDLE; next command can be accepted the following cycle.
- Latency from accept edge to rsp_valid high:
  - LOAD/CLEAR: 3 cycles.
  - COUNT with N>0: N+2 cycles.
  - COUNT with N=0: 2 cycles.
- cmd_ready=0 in every non-IDLE state; one command outstanding maximum.
- Controls are idle outside DRIVE/RUN: cnt_ce=0, cnt_load_n=1, cnt_rst_n=1.
- Wrap-around: 0xF+1 -> 0x0 and 0x0-1 -> 0xF (WIDTH=4); exp wraps identically.
- Reset mid-operation: rst at any state aborts the command. No response is issued, all outputs take reset values, err_count clears, and the counter is reset via cnt_rst_n.
- rsp_ready asserted with rsp_valid=0 is ignored.

Decomposition:
- Package counter_drv_pkg:
  - typedef enum logic [1:0] cmd_op_e {OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR}.
  - typedef enum state_e {IDLE, DRIVE, RUN, SETTLE, RESP}.
  - Default WIDTH/STEP_W/ERR_W localparams.
- Sub-module counter_ref_model: holds exp and implements load/clear/±1 wrap. It is reusable by the counter's own testbench scoreboard.

Test Plan:
- After reset, LOAD data=0xA: cnt_load_n=0 for 1 cycle; rsp_valid 3 cycles after accept, rsp_count=0xA, rsp_err=0.
- COUNT_UP steps=7 from 0xA: cnt_ce=1 for exactly 7 cycles with up_down=1; rsp_count=0x1 (wrap), rsp_err=0, latency 9.
- COUNT_DOWN steps=3 from 0x1 -> rsp_count=0xE. Then COUNT_UP steps=0 -> no ce pulse, rsp_count=0xE, latency 2.
- Inject fault (counter stuck at 0x3) then LOAD 0x5: rsp_count=0x3, rsp_err=1, err_count=1. 256+ faults: err_count saturates at 0xFF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid; rsp_count/rsp_err stable, cmd_ready=0, a new cmd_valid is not accepted. Release -> IDLE next cycle.
- Assert rst during RUN of COUNT_UP steps=100: no response, cnt_rst_n=0, all outputs at reset values. Then CLEAR -> rsp_count=0, rsp_err=0.
